// File: rtl/rvc_asap_dmem.sv
// Data-memory stage: byte-addressable RAM plus a small MMIO window holding a
// TX byte FIFO and a free-running 64-bit cycle counter with a high-word snapshot.
module rvc_asap_dmem #(
  parameter logic [31:0] D_MEM_BASE    = 32'h0001_0000,
  parameter int unsigned D_MEM_SIZE    = 4096,
  parameter logic [31:0] MMIO_BASE     = 32'h0002_0000,
  parameter int unsigned TX_FIFO_DEPTH = 8
) (
  input  logic        Clock,
  input  logic        Rst,
  input  logic [31:0] AluOut,
  input  logic [31:0] RegRdData2,
  input  logic [3:0]  CtrlDMemByteEn,
  input  logic        CtrlDMemWrEn,
  input  logic        SelDMemWb,
  input  logic        CtrlSignExt,
  output logic [31:0] DMemRdData,
  output logic        MisalignErr,
  output logic [7:0]  TxData,
  output logic        TxValid,
  input  logic        TxReady
);

  localparam int unsigned RamWords = D_MEM_SIZE / 4;
  localparam int unsigned RamAw    = (RamWords > 1) ? $clog2(RamWords) : 1;
  localparam int unsigned PtrW     = $clog2(TX_FIFO_DEPTH);
  localparam int unsigned CntW     = PtrW + 1;

  // MMIO register offsets (AluOut[3:2])
  localparam logic [1:0] RegTxData  = 2'd0;
  localparam logic [1:0] RegStatus  = 2'd1;
  localparam logic [1:0] RegCycleLo = 2'd2;
  localparam logic [1:0] RegCycleHi = 2'd3;

  logic [31:0]     ram_mem [RamWords];
  logic [7:0]      tx_mem  [TX_FIFO_DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [63:0]     cycle_q;
  logic [31:0]     hi_snap_q;

  logic [1:0]      off;
  logic            is_byte, is_half, is_word, misaligned, access;
  logic            ram_hit, mmio_hit, mmio_ok;
  logic [31:0]     ram_off;
  logic [RamAw-1:0] ram_idx;
  logic [3:0]      wr_lanes;
  logic [31:0]     wr_data, rd_word, rd_shift, ram_rdata, mmio_rdata;
  logic            full, empty, push_req, push, pop, ram_we, lo_load, ovf_clear;
  logic [7:0]      count8;

  // Address decode, alignment and RAM indexing
  always_comb begin
    off        = AluOut[1:0];
    is_byte    = (CtrlDMemByteEn == 4'b0001);
    is_half    = (CtrlDMemByteEn == 4'b0011);
    is_word    = (CtrlDMemByteEn == 4'b1111);
    access     = CtrlDMemWrEn || SelDMemWb;
    misaligned = (is_half && (off == 2'd3)) || (is_word && (off != 2'd0));
    ram_hit    = ({1'b0, AluOut} >= {1'b0, D_MEM_BASE}) &&
                 ({1'b0, AluOut} < ({1'b0, D_MEM_BASE} + 33'(D_MEM_SIZE)));
    mmio_hit   = (AluOut[31:4] == MMIO_BASE[31:4]);
    // Byte/half MMIO accesses fall through as unmapped
    mmio_ok    = mmio_hit && is_word && !misaligned;
    ram_off    = AluOut - D_MEM_BASE;
    ram_idx    = ram_off[RamAw+1:2];
    wr_lanes   = 4'(CtrlDMemByteEn << off);
    wr_data    = RegRdData2 << {off, 3'b000};
    ram_we     = CtrlDMemWrEn && !Rst && ram_hit && !misaligned &&
                 (is_byte || is_half || is_word);
    MisalignErr = access && misaligned;
  end

  // RAM write; contents are intentionally not reset
  always_ff @(posedge Clock) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_lanes[i]) ram_mem[ram_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Load path: shift, mask and optionally sign-extend; MMIO register mux
  always_comb begin
    rd_word  = ram_mem[ram_idx];
    rd_shift = rd_word >> {off, 3'b000};
    if (is_byte)      ram_rdata = {{24{CtrlSignExt & rd_shift[7]}}, rd_shift[7:0]};
    else if (is_half) ram_rdata = {{16{CtrlSignExt & rd_shift[15]}}, rd_shift[15:0]};
    else if (is_word) ram_rdata = rd_shift;
    else              ram_rdata = 32'h0;

    count8 = 8'(count_q);
    case (AluOut[3:2])
      RegStatus:  mmio_rdata = {16'b0, count8, 5'b0, overflow_q, full, empty};
      RegCycleLo: mmio_rdata = cycle_q[31:0];
      RegCycleHi: mmio_rdata = hi_snap_q;
      default:    mmio_rdata = 32'h0;
    endcase

    DMemRdData = 32'h0;
    if (SelDMemWb && !misaligned && (CtrlDMemByteEn != 4'b0000)) begin
      if (ram_hit)      DMemRdData = ram_rdata;
      else if (mmio_ok) DMemRdData = mmio_rdata;
    end
  end

  // FIFO control: a push into a full FIFO lands only if the head pops this cycle
  always_comb begin
    full      = (count_q == CntW'(TX_FIFO_DEPTH));
    empty     = (count_q == '0);
    TxValid   = !empty;
    TxData    = tx_mem[rd_ptr_q];
    pop       = TxValid && TxReady;
    push_req  = CtrlDMemWrEn && mmio_ok && (AluOut[3:2] == RegTxData);
    push      = push_req && (!full || pop);
    ovf_clear = CtrlDMemWrEn && mmio_ok && (AluOut[3:2] == RegStatus) && RegRdData2[2];
    lo_load   = SelDMemWb && mmio_ok && (AluOut[3:2] == RegCycleLo);

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;

    // Set wins over a same-cycle clear
    overflow_d = overflow_q;
    if (ovf_clear)               overflow_d = 1'b0;
    if (push_req && full && !pop) overflow_d = 1'b1;
  end

  // FIFO storage
  always_ff @(posedge Clock) begin
    if (push && !Rst) tx_mem[wr_ptr_q] <= RegRdData2[7:0];
  end

  // FIFO pointers, overflow flag, cycle counter and high-word snapshot
  always_ff @(posedge Clock) begin
    if (Rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      cycle_q    <= 64'h0;
      hi_snap_q  <= 32'h0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      cycle_q    <= cycle_q + 64'd1;
      if (lo_load) hi_snap_q <= cycle_q[63:32];
    end
  end

endmodule

// File: doc/rvc_asap_dmem.md
Name: rvc_asap_dmem

Overview:
Data-memory stage directly downstream of the single-cycle core. It consumes the core's D_MEM request signals: address, store data, byte enable, write enable, load select and sign-extend. It returns load data combinationally within the same cycle. Besides the byte-addressable RAM, it holds a small MMIO window with a TX byte FIFO (valid/ready drain to an external consumer) and a free-running 64-bit cycle counter with a coherent high-word snapshot.

Parameters:
D_MEM_BASE, 32'h0001_0000, byte base address of the RAM region.
D_MEM_SIZE, 4096, RAM size in bytes; power of two, >= 4.
MMIO_BASE, 32'h0002_0000, base of the 16-byte MMIO window.
TX_FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..128.

Ports:
Clock  in  1  core clock; all state updates on rising edge.
Rst  in  1  synchronous, active-high reset.
AluOut  in  32  byte address from core.
RegRdData2  in  32  store data, right-aligned.
CtrlDMemByteEn  in  4  4'b0001 byte, 4'b0011 half, 4'b1111 word, 4'b0000 no access.
CtrlDMemWrEn  in  1  store request this cycle.
SelDMemWb  in  1  load request this cycle.
CtrlSignExt  in  1  sign-extend load result.
DMemRdData  out  32  load result, combinational.
MisalignErr  out  1  combinational; high for a misaligned load/store this cycle.
TxData  out  8  FIFO head byte.
TxValid  out  1  FIFO non-empty.
TxReady  in  1  consumer accepts head when TxValid&&TxReady at a rising edge.

Behaviour:
- Only one clock (Clock); reset is synchronous, active-high on Rst. No other clocks or async resets.
- Decode: RAM hit when D_MEM_BASE <= AluOut < D_MEM_BASE+D_MEM_SIZE. MMIO hit when AluOut[31:4]==MMIO_BASE[31:4]. Anything else is unmapped.
- Offset: off = AluOut[1:0]. Misaligned when (half && off==3) or (word && off!=0). Misaligned access: MisalignErr=1, DMemRdData=0, no state change.
- RAM read (async): word W at AluOut[31:2]. Shift W right by 8*off, mask to byte/half/word. If CtrlSignExt, replicate bit 7 (byte) or bit 15 (half).
- RAM write: at rising edge when CtrlDMemWrEn && !Rst && RAM hit && aligned. Lanes = CtrlDMemByteEn<<off. Data = RegRdData2<<(8*off). Unwritten lanes are preserved. RAM contents are not reset.
- DMemRdData = 0 whenever SelDMemWb==0, on unmapped reads, and when ByteEn==0.
- MMIO map (word accesses only; byte/half MMIO accesses behave as unmapped):
  - 0x0 TX_DATA: write pushes RegRdData2[7:0]; reads return 0.
  - 0x4 STATUS: read {16'b0, count[7:0], 5'b0, overflow, full, empty}. A write with bit2=1 clears overflow.
  - 0x8 CYCLE_LO: read returns live cycle[31:0]. At the same edge, a load here latches cycle[63:32] into hi_snap.
  - 0xC CYCLE_HI: read returns hi_snap.
- Cycle counter: 64 bits, cleared by Rst, +1 every non-reset cycle, wraps to 0. A CYCLE_LO load at cycle value N returns N.
- TX FIFO rules:
  - Push when a TX_DATA store occurs and (!full or pop in same cycle). Push when full without a pop is dropped and sets sticky overflow.
  - Pop when TxValid&&TxReady.
  - Simultaneous push+pop keeps count unchanged. An empty FIFO cannot pop, so a push lands.
  - Overflow set and clear in the same cycle: set wins.
  - TxData is the registered head entry and is stable while TxValid&&!TxReady.
  - Pointers wrap modulo depth; count ranges 0..TX_FIFO_DEPTH.
- Reset values: TxValid=0, overflow=0, count=0, cycle=0, hi_snap=0. TxData is don't-care while TxValid=0. DMemRdData and MisalignErr follow their combinational rules.
- Reset mid-operation: a store coincident with Rst is ignored, and queued bytes are discarded.

Test Plan:
- SW 0xDEADBEEF to D_MEM_BASE+0x10, then LW -> 0xDEADBEEF. LH at +0x12 with SignExt -> 0xFFFFDEAD. LHU -> 0x0000DEAD.
- SB 0x80 to +0x23, then LB -> 0xFFFFFF80, LBU -> 0x00000080. LW +0x20 shows only byte 3 changed from its prior value.
- LW at D_MEM_BASE+0x2 -> MisalignErr=1, DMemRdData=0. SH at off 3 -> memory unchanged.
- TxReady=0, 9 TX_DATA stores 0x01..0x09 -> STATUS=0x0806 (count 8, full, overflow). Raise TxReady -> TxData sequence 0x01..0x08, then TxValid=0. Write STATUS 0x4 -> overflow=0.
- Full FIFO with TxReady=1 plus a store 0xAA in the same cycle -> count stays 8, 0xAA is drained last, overflow stays 0.
- After 100 cycles out of reset: LW CYCLE_LO -> 100, LW CYCLE_HI -> 0. Force cycle to 0xFFFFFFFF via a long run or bench preload: LO read -> 0xFFFFFFFF, next-cycle HI read -> 0. Rst with 3 queued bytes -> TxValid=0 on the next cycle.
